maj_sampler: RTL
================

# maj_sampler

Upstream feeder for the 3-input majority voter `ma`. It samples a single noisy serial line (`din`) at a programmable rate and assembles the last three samples into a 3-bit window. It presents that window on `win`, which drives the voter's `inp`, together with a one-cycle `win_valid` strobe. It supports two windowing modes: sliding (one new window per sample) and block (one window per three fresh samples).

## Interface
Parameters:
- `DIV`, default 4: sample period in clock cycles. Legal range is ≥1; `DIV=1` samples every enabled cycle.
- `CNT_W`, default 8: width of the window counter.

Ports:
- `clk`, in, 1: single system clock. All logic is on the rising edge.
- `rst_n`, in, 1: asynchronous active-low reset.
- `en`, in, 1: sampling enable. While low the block idles.
- `din`, in, 1: raw serial input. The block samples it directly and does not synchronise it.
- `mode`, in, 1: 0 = sliding window, 1 = block window. It is latched on the IDLE→FILL transition only.
- `win`, out, 3: current window. `win[2]` is the oldest sample and `win[0]` the newest. It connects to the voter `inp`.
- `win_valid`, out, 1: one-cycle pulse, high in the cycle a new `win` first appears.
- `win_cnt`, out, CNT_W: number of windows emitted since reset. It saturates at all-ones.
- `busy`, out, 1: high in FILL and RUN.

## Operation
- **Reset:** `win`=0, `win_valid`=0, `win_cnt`=0, `busy`=0, state=IDLE, prescaler=0, fill=0, internal shift register=0.
- **Prescaler:** counts 0..DIV-1 while `en`=1. A tick occurs when the count equals DIV-1, after which the count wraps to 0. It is held at 0 whenever `en`=0.
- **On each tick:** the shift register loads `{sr[1:0], din}`. The fill count increments and saturates at 3.
- **States:**
  - IDLE: `en`=0. When `en`=1, latch `mode`, clear fill, and go to FILL.
  - FILL: the tick that brings fill to 3 emits a window and moves to RUN.
  - RUN, sliding mode: every tick emits a window.
  - RUN, block mode: the emit tick also clears fill to 0 and returns to FILL. Windows in this mode never share samples.
  - Any state with `en`=0 goes to IDLE. The prescaler, fill and shift register clear. `win` and `win_cnt` hold their last values.
- **Emit:** `win` ← new shift register value, `win_valid` ← 1, and `win_cnt` ← `win_cnt`+1 unless it is already all-ones. `win` changes only on an emit, so the voter input stays stable between strobes.
- **Mode change:** a change of `mode` while `busy` has no effect until the next IDLE→FILL transition.
- **Async reset mid-window:** all state clears immediately and any partial window is discarded.

## Timing
- Let cycle 0 be the first rising edge with `en`=1 while in IDLE. Cycle 0 performs the IDLE→FILL transition and the prescaler starts counting.
- Tick k (k≥1) samples `din` at the edge of cycle k·DIV−1.
- Emit latency: `din` sampled at a tick edge appears in `win`, with `win_valid`=1, one cycle later.
- First window: `win_valid` is high at cycle 3·DIV.
- Subsequent windows, sliding mode: one every DIV cycles.
- Subsequent windows, block mode: one every 3·DIV cycles.
- `en` falling: the same edge clears the prescaler and fill, and no emit occurs on that edge. `win_valid` is never high two cycles in a row unless DIV=1 in sliding mode.
- `busy` is registered and reflects state one cycle after the transition edge.

## Structure
- **Shared package `maj_pkg`:** holds the state encoding (IDLE/FILL/RUN) and the `WIN_W`=3 constant. The voter and its bench use the same constant.
- **Sub-module `tick_gen`:** the parameterised prescaler with inputs `clk`, `rst_n`, `en` and output `tick`. The FSM, shift register and counter live in `maj_sampler`.

## Test plan
- **Reset and first window:** `DIV`=4, sliding mode; release reset, raise `en` at cycle 0, drive `din`=1,1,0 around the ticks at cycles 3, 7 and 11. Required: `win_valid` pulses at cycle 12 with `win`=3'b110 and `win_cnt`=1, and the voter output is 1.
- **Sliding stream:** continue from the first test with `din`=0,0,1 on the next three ticks. Required: windows 3'b100, 3'b000, 3'b001 at cycles 16, 20 and 24, and `win_cnt`=4.
- **Block mode:** `DIV`=2, `mode`=1, `din` pattern 1,0,1,1,1,0. Required: exactly two strobes, at cycles 6 and 12, with `win`=3'b101 and then 3'b110.
- **Enable drop mid-fill:** drop `en` after two ticks, then re-enable. Required: no strobe is produced, `win`/`win_cnt` are held, and the first strobe after re-enable arrives 3·DIV cycles later.
- **Async reset mid-run:** assert `rst_n`=0 between clock edges. Required: all outputs are 0 immediately, before the next edge.
- **Saturation and DIV=1:** `CNT_W`=2, `DIV`=1, sliding mode, run 10 windows. Required: `win_valid` is high every cycle from cycle 3, and `win_cnt` stops at 3.

Source files
------------

// File: rtl/maj_pkg.sv
// Shared definitions for the majority-voter front end: window width,
// sampler state encoding and the shift-register helper.
package maj_pkg;

  localparam int WIN_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  // Shift a new sample into the newest position; the oldest falls off the top.
  function automatic logic [WIN_W-1:0] shift_in(input logic [WIN_W-1:0] sr,
                                                input logic              b);
    return {sr[WIN_W-2:0], b};
  endfunction

endpackage

// File: rtl/maj_sampler_tick_gen.sv
// Sample-rate prescaler: one tick every DIV enabled cycles, held at zero
// while disabled so every enable starts a fresh sample period.
module tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [PW-1:0] cnt;

  // The tick is combinational so it lines up with the edge at count DIV-1.
  assign tick = en && (cnt == PW'(DIV - 1));

  // Count 0..DIV-1 while enabled, wrap on tick, clear when disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + PW'(1);
    end
  end

endmodule

// File: rtl/maj_sampler.sv
// Serial-line sampler feeding the 3-input majority voter. Samples din on
// every prescaler tick, keeps the last three samples and presents them as a
// window with a one-cycle strobe, in sliding or block windowing mode.
//
// Handshake: win_valid is a one-cycle strobe with no back-pressure; win is
// stable from that strobe until the next one, so the consumer may sample it
// at any time in between.
module maj_sampler
  import maj_pkg::*;
#(
  parameter int DIV   = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             din,
  input  logic             mode,
  output logic [WIN_W-1:0] win,
  output logic             win_valid,
  output logic [CNT_W-1:0] win_cnt,
  output logic             busy
);

  state_t           state;
  logic [1:0]       fill;
  logic [WIN_W-1:0] sr;
  logic [WIN_W-1:0] sr_nx;
  logic             mode_q;
  logic             tick;

  tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .tick  (tick)
  );

  assign sr_nx = shift_in(sr, din);

  // Sampler FSM with registered window, strobe, counter and busy flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      fill      <= 2'd0;
      sr        <= '0;
      mode_q    <= 1'b0;
      win       <= '0;
      win_valid <= 1'b0;
      win_cnt   <= '0;
      busy      <= 1'b0;
    end else begin
      win_valid <= 1'b0;
      if (!en) begin
        // Disabling abandons any partial window; win and win_cnt hold.
        state <= ST_IDLE;
        fill  <= 2'd0;
        sr    <= '0;
        busy  <= 1'b0;
      end else begin
        busy <= 1'b1;
        case (state)
          ST_IDLE: begin
            // With DIV=1 the very first enabled edge is already a tick.
            mode_q <= mode;
            state  <= ST_FILL;
            if (tick) begin
              sr   <= sr_nx;
              fill <= 2'd1;
            end else begin
              fill <= 2'd0;
            end
          end
          ST_FILL: begin
            if (tick) begin
              sr <= sr_nx;
              if (fill == 2'd2) begin
                win       <= sr_nx;
                win_valid <= 1'b1;
                if (win_cnt != '1) win_cnt <= win_cnt + CNT_W'(1);
                if (mode_q) begin
                  // Block mode: next window must use three fresh samples.
                  fill <= 2'd0;
                end else begin
                  fill  <= 2'd3;
                  state <= ST_RUN;
                end
              end else begin
                fill <= fill + 2'd1;
              end
            end
          end
          ST_RUN: begin
            if (tick) begin
              sr        <= sr_nx;
              win       <= sr_nx;
              win_valid <= 1'b1;
              if (win_cnt != '1) win_cnt <= win_cnt + CNT_W'(1);
              if (mode_q) begin
                fill  <= 2'd0;
                state <= ST_FILL;
              end
            end
          end
          default: begin
            state <= ST_IDLE;
            fill  <= 2'd0;
          end
        endcase
      end
    end
  end

endmodule
